apa102_stream_out: RTL and testbench

//  Parametrised APA102 serialiser; successor to the fixed 16-bit/24-bit streamer. Fetches a

---
 rtl/apa102_stream_out_if.sv | 39 +++
 rtl/apa102_stream_out.sv | 221 ++++++++++++++++++++++
 tb/tb_apa102_stream_out.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apa102_stream_out_if.sv
// apa102_stream_out_if
//   Host, page-memory and LED-line signals of the APA102 serialiser.
//   master : the serialiser (drives status, read requests and the LED lines)
//   slave  : the environment (host control inputs and memory read returns)
//   Host: start, word_count, start_address, clock_divisor, global_brightness,
//         busy, done, underrun
//   Memory: read_address, read_request, read_data, read_valid
//   LED: data_out (DI), clock_out (CI)
interface apa102_stream_out_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                  start;
   logic [15:0]           word_count;
   logic [ADDR_WIDTH-1:0] start_address;
   logic [7:0]            clock_divisor;
   logic [4:0]            global_brightness;
   logic                  busy;
   logic                  done;
   logic                  underrun;
   logic [ADDR_WIDTH-1:0] read_address;
   logic                  read_request;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  read_valid;
   logic                  data_out;
   logic                  clock_out;

   modport master (
      input  start, word_count, start_address, clock_divisor, global_brightness,
      input  read_data, read_valid,
      output busy, done, underrun, read_address, read_request, data_out, clock_out
   );

   modport slave (
      output start, word_count, start_address, clock_divisor, global_brightness,
      output read_data, read_valid,
      input  busy, done, underrun, read_address, read_request, data_out, clock_out
   );
endinterface

// File: rtl/apa102_stream_out.sv
// apa102_stream_out
//   Fetches word_count words from page memory, repacks them MSB first into
//   PIXEL_BITS-wide pixels (last pixel zero padded) and emits an APA102 frame:
//   32 zero bits, per pixel {3'b111, brightness} + colour, then
//   32 + ceil(npix/2) one bits, then GAP_TICKS idle ticks before done.
//   SCK is paced by a clock-enable tick every clock_divisor+1 clks; each bit is
//   tick A (data, CI low) then tick B (CI high).
//   Ports: clk, rst (sync, active-high), bus (apa102_stream_out_if.master).
//   Build option: define APA102_UNDERRUN_BLANK_EN to replace a starved word
//   with zeros instead of stalling the stream; the late word is dropped.
//
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_START | 32-bit zero start frame
//   S_HDR   | 8-bit pixel header {111, brightness}
//   S_PIX   | PIXEL_BITS colour bits
//   S_END   | 32 + ceil(npix/2) one bits
//   S_GAP   | GAP_TICKS quiet ticks, then done
module apa102_stream_out #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int PIXEL_BITS = 24,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_TICKS  = 1024
) (
   input  logic                clk,
   input  logic                rst,
   apa102_stream_out_if.master bus
);
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int PTW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int WIW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_HDR, S_PIX, S_END, S_GAP} state_t;

   state_t                state;
   logic                  busy, done, underrun, data_out, clock_out, phase;
   logic [ADDR_WIDTH-1:0] read_address;
   logic [31:0]           bit_cnt, pix_left, end_len, npix_calc;
   logic [7:0]            div_cnt, div_r, hdr_byte;
   logic [4:0]            bright_r;
   logic [15:0]           req_left, word_left;
   logic [WIW-1:0]        word_idx;
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]         fifo_count, outstanding;
   logic                  tick, req, rv_ok, push, pop, need_word, stall, blank_now;
   logic                  a_step, cur_bit;

   assign tick      = busy && (div_cnt == 8'd0);
   assign req       = busy && (req_left != 16'd0) &&
                      (({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(FIFO_DEPTH));
   assign rv_ok     = bus.read_valid && (outstanding != '0);
   assign need_word = (state == S_PIX) && (word_left != 16'd0);
   assign hdr_byte  = {3'b111, bright_r};
   assign npix_calc = (32'(bus.word_count) * 32'(DATA_WIDTH) + 32'(PIXEL_BITS - 1))
                      / 32'(PIXEL_BITS);

`ifdef APA102_UNDERRUN_BLANK_EN
   logic [CW-1:0] discard;
   logic          blank_word, blank_start;
   assign stall       = 1'b0;
   // An empty FIFO can only be seen at a word start: the head stays until its last bit.
   assign blank_now   = need_word && (blank_word || fifo_count == '0);
   assign blank_start = tick && !phase && blank_now && !blank_word;
   // A word landing on the very clk it is blanked is the late word itself.
   assign push        = rv_ok && (discard == '0) && !blank_start;
`else
   assign stall       = need_word && (fifo_count == '0);
   assign blank_now   = 1'b0;
   assign push        = rv_ok;
`endif

   assign a_step = tick && !phase && (state != S_IDLE) && (state != S_GAP) && !stall;
   assign pop    = a_step && need_word && !blank_now && (word_idx == '0);

   always_comb begin
      cur_bit = 1'b0;
      case (state)
         S_HDR:   cur_bit = hdr_byte[bit_cnt[2:0]];
         S_PIX:   cur_bit = need_word && !blank_now && fifo_mem[rd_ptr][word_idx];
         S_END:   cur_bit = 1'b1;
         default: cur_bit = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.read_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         underrun     <= 1'b0;
         data_out     <= 1'b0;
         clock_out    <= 1'b0;
         phase        <= 1'b0;
         read_address <= '0;
         bit_cnt      <= '0;
         pix_left     <= '0;
         end_len      <= '0;
         div_cnt      <= '0;
         div_r        <= '0;
         bright_r     <= '0;
         req_left     <= '0;
         word_left    <= '0;
         word_idx     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count   <= '0;
         outstanding  <= '0;
      end else begin
         done        <= 1'b0;
         outstanding <= outstanding + CW'(req) - CW'(rv_ok);
         fifo_count  <= fifo_count + CW'(push) - CW'(pop);
         if (req) begin
            read_address <= read_address + ADDR_WIDTH'(1);
            req_left     <= req_left - 16'd1;
         end
         if (push) wr_ptr <= (wr_ptr == PTW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTW'(1);
         if (pop)  rd_ptr <= (rd_ptr == PTW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTW'(1);
         if (busy) div_cnt <= (div_cnt == 8'd0) ? div_r : div_cnt - 8'd1;

         if (state == S_IDLE) begin
            if (bus.start) begin
               state        <= S_START;
               busy         <= 1'b1;
               underrun     <= 1'b0;
               phase        <= 1'b0;
               bit_cnt      <= 32'd31;
               div_cnt      <= bus.clock_divisor;
               div_r        <= bus.clock_divisor;
               bright_r     <= bus.global_brightness;
               read_address <= bus.start_address;
               req_left     <= bus.word_count;
               word_left    <= bus.word_count;
               word_idx     <= WIW'(DATA_WIDTH - 1);
               pix_left     <= npix_calc;
               end_len      <= 32'd32 + ((npix_calc + 32'd1) >> 1);
            end
         end else if (tick) begin
            if (state == S_GAP) begin
               clock_out <= 1'b0;
               data_out  <= 1'b0;
               if (bit_cnt == 32'd0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt - 32'd1;
               end
            end else if (!phase) begin
               clock_out <= 1'b0;
               if (stall) begin
                  underrun <= 1'b1;
               end else begin
                  data_out <= cur_bit;
                  phase    <= 1'b1;
                  if (blank_now) underrun <= 1'b1;
                  if (need_word) begin
                     if (word_idx == '0) begin
                        word_idx  <= WIW'(DATA_WIDTH - 1);
                        word_left <= word_left - 16'd1;
                     end else begin
                        word_idx <= word_idx - WIW'(1);
                     end
                  end
               end
            end else begin
               clock_out <= 1'b1;
               phase     <= 1'b0;
               if (bit_cnt != 32'd0) begin
                  bit_cnt <= bit_cnt - 32'd1;
               end else begin
                  case (state)
                     S_START: begin
                        state   <= (pix_left == 32'd0) ? S_END : S_HDR;
                        bit_cnt <= (pix_left == 32'd0) ? end_len - 32'd1 : 32'd7;
                     end
                     S_HDR: begin
                        state   <= S_PIX;
                        bit_cnt <= 32'(PIXEL_BITS - 1);
                     end
                     S_PIX: begin
                        pix_left <= pix_left - 32'd1;
                        state    <= (pix_left == 32'd1) ? S_END : S_HDR;
                        bit_cnt  <= (pix_left == 32'd1) ? end_len - 32'd1 : 32'd7;
                     end
                     default: begin
                        state   <= S_GAP;
                        bit_cnt <= 32'(GAP_TICKS - 1);
                     end
                  endcase
               end
            end
         end
      end
   end

`ifdef APA102_UNDERRUN_BLANK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         discard    <= '0;
         blank_word <= 1'b0;
      end else begin
         discard <= discard + CW'(blank_start) - CW'(rv_ok && (discard != '0 || blank_start));
         if (a_step && need_word) blank_word <= blank_now && (word_idx != '0);
      end
   end
`endif

   assign bus.busy         = busy;
   assign bus.done         = done;
   assign bus.underrun     = underrun;
   assign bus.read_address = read_address;
   assign bus.read_request = req;
   assign bus.data_out     = data_out;
   assign bus.clock_out    = clock_out;
endmodule

// File: tb/tb_apa102_stream_out.sv
// tb_apa102_stream_out
//   Directed + randomized frames for apa102_stream_out (16-bit words, 24-bit pixels).
//   A memory responder returns words in order; the expected bit stream is built
//   from the frame rules (start/header/pixels/end) and compared to the bits
//   captured on rising clock_out.
module tb_apa102_stream_out;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   apa102_stream_out_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

   apa102_stream_out #(
      .ADDR_WIDTH(16), .DATA_WIDTH(16), .PIXEL_BITS(24), .FIFO_DEPTH(4), .GAP_TICKS(1024)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   int          errors = 0;
   int          checks = 0;
   logic [15:0] mem [0:65535];
   bit          exp_q[$];
   bit          cap_q[$];
   logic [15:0] addr_log[$];

   // Responder-owned state.
   logic [15:0] pend_a[$];
   int          pend_t[$];
   int          now_n   = 0;
   int          req_idx = 0;
   // Written by the stimulus only.
   int          delay_target = -1;
   int          delay_clks   = 0;

   always @(negedge clk) begin
      now_n++;
      if (rst) begin
         pend_a.delete();
         pend_t.delete();
         bus.read_valid = 1'b0;
         bus.read_data  = 16'h0;
      end else begin
         if (pend_a.size() > 0 && pend_t[0] <= now_n) begin
            bus.read_valid = 1'b1;
            bus.read_data  = mem[pend_a[0]];
            void'(pend_a.pop_front());
            void'(pend_t.pop_front());
         end else begin
            bus.read_valid = 1'b0;
         end
         if (bus.read_request) begin
            pend_a.push_back(bus.read_address);
            pend_t.push_back(now_n + 1 + ((req_idx == delay_target) ? delay_clks : 0));
            addr_log.push_back(bus.read_address);
            req_idx++;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void build_expect(input int wc, input logic [15:0] a,
                                        input logic [4:0] br, input int blank_idx);
      bit          pq[$];
      int          npix;
      logic [15:0] w;
      logic [15:0] ad;
      logic [7:0]  hdr;
      exp_q.delete();
      repeat (32) exp_q.push_back(1'b0);
      npix = (wc * 16 + 23) / 24;
      for (int i = 0; i < wc; i++) begin
         ad = a + 16'(i);
         w  = (i == blank_idx) ? 16'h0 : mem[ad];
         for (int b = 15; b >= 0; b--) pq.push_back(w[b]);
      end
      while (pq.size() < npix * 24) pq.push_back(1'b0);
      hdr = {3'b111, br};
      for (int p = 0; p < npix; p++) begin
         for (int b = 7; b >= 0; b--) exp_q.push_back(hdr[b]);
         for (int b = 0; b < 24; b++) exp_q.push_back(pq[p * 24 + b]);
      end
      repeat (32 + (npix + 1) / 2) exp_q.push_back(1'b1);
   endfunction

   task automatic run_frame(input string tag, input int wc, input logic [15:0] a,
                            input logic [7:0] dv, input logic [4:0] br, input bit fill,
                            input int blank_idx, input int dly_word, input int dly,
                            input bit poke, output logic ur, output int mlow);
      int   base, budget, lr, mism;
      bit   got_done;
      logic pc;
      logic [15:0] ad;
      if (fill) for (int i = 0; i < wc; i++) begin
         ad = a + 16'(i);
         mem[ad] = 16'($urandom);
      end
      build_expect(wc, a, br, blank_idx);
      delay_target = (dly_word >= 0) ? req_idx + dly_word : -1;
      delay_clks   = dly;
      base = addr_log.size();
      cap_q.delete();
      bus.word_count        = 16'(wc);
      bus.start_address     = a;
      bus.clock_divisor     = dv;
      bus.global_brightness = br;
      bus.start             = 1'b1;
      @(negedge clk);
      bus.start             = 1'b0;
      bus.word_count        = 16'($urandom);
      bus.start_address     = 16'($urandom);
      bus.clock_divisor     = 8'($urandom);
      bus.global_brightness = 5'($urandom);
      chk({tag, " busy_after_start"}, 64'(bus.busy), 64'(1));
      budget = (exp_q.size() * 2 + 1040) * (int'(dv) + 1) + dly + 200;
      got_done = 1'b0;
      lr = 0;
      mlow = 0;
      pc = bus.clock_out;
      for (int c = 0; c < budget && !got_done; c++) begin
         @(negedge clk);
         if (poke && c == 40) bus.start = 1'b1;
         if (poke && c == 41) bus.start = 1'b0;
         if (bus.clock_out && !pc) cap_q.push_back(bus.data_out);
         if (!bus.clock_out && cap_q.size() < exp_q.size()) begin
            lr++;
            if (lr > mlow) mlow = lr;
         end else begin
            lr = 0;
         end
         pc = bus.clock_out;
         if (bus.done) got_done = 1'b1;
      end
      bus.start = 1'b0;
      ur = bus.underrun;
      chk({tag, " done_seen"}, 64'(got_done), 64'(1));
      chk({tag, " bit_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
      mism = 0;
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
         if (cap_q[i] != exp_q[i]) mism++;
      chk({tag, " bit_mismatches"}, 64'(mism), 64'(0));
      @(negedge clk);
      chk({tag, " idle_after_done"}, 64'({bus.done, bus.busy}), 64'(0));
      chk({tag, " request_count"}, 64'(addr_log.size() - base), 64'(wc));
      mism = 0;
      for (int i = 0; i < wc && base + i < addr_log.size(); i++)
         if (addr_log[base + i] !== a + 16'(i)) mism++;
      chk({tag, " address_sequence"}, 64'(mism), 64'(0));
   endtask

   initial begin
      logic        ur;
      int          ml, edges;
      bit          reached;
      logic        pc;
      logic [15:0] a;

      rst                   = 1'b1;
      bus.start             = 1'b0;
      bus.word_count        = 16'h0;
      bus.start_address     = 16'h0;
      bus.clock_divisor     = 8'h0;
      bus.global_brightness = 5'h0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({bus.busy, bus.done, bus.underrun, bus.read_request,
                               bus.data_out, bus.clock_out, bus.read_address}), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Reference frame: three words, two pixels, 33-bit end frame.
      a = 16'h0100;
      mem[16'h0100] = 16'hAABB;
      mem[16'h0101] = 16'hCCDD;
      mem[16'h0102] = 16'hEEFF;
      run_frame("ref3", 3, a, 8'd0, 5'h1F, 1'b0, -1, -1, 0, 1'b0, ur, ml);
      chk("ref3 underrun", 64'(ur), 64'(0));

      run_frame("one_word", 1, 16'h2000, 8'd1, 5'h0A, 1'b1, -1, -1, 0, 1'b0, ur, ml);
      run_frame("zero_words", 0, 16'h3000, 8'd0, 5'h11, 1'b1, -1, -1, 0, 1'b0, ur, ml);
      run_frame("wrap", 3, 16'hFFFF, 8'd0, 5'h03, 1'b1, -1, -1, 0, 1'b0, ur, ml);

`ifdef APA102_UNDERRUN_BLANK_EN
      run_frame("blank", 3, 16'h4000, 8'd3, 5'h15, 1'b1, 2, 2, 800, 1'b0, ur, ml);
      chk("blank underrun", 64'(ur), 64'(1));
      chk("blank no_stall", 64'(ml < 20), 64'(1));
`else
      run_frame("stall", 3, 16'h4000, 8'd3, 5'h15, 1'b1, -1, 2, 800, 1'b0, ur, ml);
      chk("stall underrun", 64'(ur), 64'(1));
      chk("stall clock_low", 64'(ml > 100), 64'(1));
`endif

      // Next start must clear the sticky underrun.
      run_frame("after_underrun", 2, 16'h5000, 8'd0, 5'h07, 1'b1, -1, -1, 0, 1'b0, ur, ml);
      chk("after_underrun underrun", 64'(ur), 64'(0));

      for (int r = 0; r < 3; r++) begin
         run_frame($sformatf("rand%0d", r), int'($urandom_range(1, 6)), 16'($urandom),
                   8'($urandom_range(0, 2)), 5'($urandom), 1'b1, -1, -1, 0, 1'b1, ur, ml);
         chk($sformatf("rand%0d underrun", r), 64'(ur), 64'(0));
      end

      // Reset in the middle of the first pixel's colour bits.
      a = 16'h6000;
      for (int i = 0; i < 3; i++) mem[a + 16'(i)] = 16'($urandom);
      cap_q.delete();
      bus.word_count        = 16'd3;
      bus.start_address     = a;
      bus.clock_divisor     = 8'd0;
      bus.global_brightness = 5'h1F;
      bus.start             = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      reached = 1'b0;
      pc = bus.clock_out;
      for (int c = 0; c < 400 && !reached; c++) begin
         @(negedge clk);
         if (bus.clock_out && !pc) cap_q.push_back(bus.data_out);
         pc = bus.clock_out;
         if (cap_q.size() >= 45) reached = 1'b1;
      end
      chk("midpix reached", 64'(reached), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      chk("midpix reset_outputs", 64'({bus.busy, bus.done, bus.underrun, bus.read_request,
                                      bus.data_out, bus.clock_out, bus.read_address}), 64'(0));
      edges = 0;
      pc = bus.clock_out;
      repeat (4) begin
         @(negedge clk);
         if (bus.clock_out && !pc) edges++;
         pc = bus.clock_out;
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.clock_out && !pc) edges++;
         pc = bus.clock_out;
      end
      chk("midpix no_edges", 64'(edges), 64'(0));
      run_frame("post_reset", 3, 16'h7000, 8'd0, 5'h1F, 1'b1, -1, -1, 0, 1'b0, ur, ml);
      chk("post_reset underrun", 64'(ur), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
